sr_latch_arbiter: RTL and testbench

- Clocked controller that shares one NOR-based SR latch between NREQ requesters.
- Drives the latch's s/r inputs with timed pulses and never drives s and r high together.
- Reads the latch's q back through a synchroniser and confirms each operation to the requester it served.
- Sits between the synchronous control logic and the asynchronous latch cell.

---
 rtl/sr_latch_arbiter.sv | 157 +++++++++++++++
 tb/tb_sr_latch_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter sharing one NOR SR latch between NREQ requesters:
// timed s/r pulses, settle gap, then a synchronised read-back check per operation.
module sr_latch_arbiter #(
  parameter int NREQ         = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_set,
  input  logic [NREQ-1:0] req_clr,
  input  logic            q_fb,
  output logic            s_drv,
  output logic            r_drv,
  output logic [NREQ-1:0] done,
  output logic            ok,
  output logic [NREQ-1:0] conflict,
  output logic            fault,
  output logic            q_state,
  output logic            busy
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int unsigned NU = NREQ;
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_DRIVE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  logic [2:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_rr;
  logic            r_op;
  logic            r_init;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_s;
  logic            r_r;
  logic            r_fault;
  logic [NREQ-1:0] r_conf;

  logic [NREQ-1:0] w_valid;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_chk_req;
  int unsigned     w_slot;

  assign w_valid = req_set ^ req_clr;

  // Round-robin scan starting at r_rr, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_slot  = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      w_slot = 32'(r_rr) + i;
      if (w_slot >= NU) w_slot = w_slot - NU;
      if (!w_found && w_valid[w_slot[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_slot[IW-1:0];
      end
    end
  end

  // The power-up clear reuses SETTLE/CHECK; r_init suppresses its done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rr    <= '0;
      r_op    <= 1'b0;
      r_init  <= 1'b1;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_fault <= 1'b0;
      r_conf  <= '0;
    end else begin
      r_sync1 <= q_fb;
      r_sync2 <= r_sync1;
      r_conf  <= req_set & req_clr;
      case (r_state)
        ST_INIT: begin
          if (r_cnt == P_LAST) begin
            r_r     <= 1'b0;
            r_cnt   <= CW'(1);
            r_state <= ST_SETTLE;
          end else begin
            r_r   <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_IDLE: begin
          if (w_found) begin
            r_idx   <= w_pick;
            r_op    <= req_set[w_pick];
            r_init  <= 1'b0;
            r_s     <= req_set[w_pick];
            r_r     <= ~req_set[w_pick];
            r_cnt   <= CW'(1);
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == P_LAST) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_cnt   <= CW'(1);
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (r_cnt == G_LAST) r_state <= ST_CHECK;
          else                 r_cnt   <= r_cnt + CW'(1);
        end
        ST_CHECK: begin
          if (!r_init) r_rr <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
          if (r_sync2 != r_op) r_fault <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_chk_req = (r_state == ST_CHECK) && !r_init;

  always_comb begin
    done = '0;
    if (w_chk_req) done = NREQ'(1) << r_idx;
  end

  assign ok       = w_chk_req && (r_sync2 == r_op);
  assign s_drv    = r_s;
  assign r_drv    = r_r;
  assign q_state  = r_sync2;
  assign fault    = r_fault;
  assign conflict = r_conf;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: transaction-timeline reference model against a
// behavioural SR latch, with directed scenarios followed by random traffic.
module tb_sr_latch_arbiter;
  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_set = '0;
  logic [N-1:0] req_clr = '0;
  logic         q_fb;
  logic         s_drv, r_drv, ok, fault, q_state, busy;
  logic [N-1:0] done, conflict;

  logic q_latch = 1'b1;
  logic stuck   = 1'b0;

  sr_latch_arbiter #(.NREQ(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req_set(req_set), .req_clr(req_clr), .q_fb(q_fb),
    .s_drv(s_drv), .r_drv(r_drv), .done(done), .ok(ok), .conflict(conflict),
    .fault(fault), .q_state(q_state), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stuck)      q_latch <= 1'b0;
    else if (s_drv) q_latch <= 1'b1;
    else if (r_drv) q_latch <= 1'b0;
  end
  assign q_fb = q_latch;

  // Reference model: cycle index since reset plus the one scheduled operation.
  int           m_k, m_g, m_free, m_idx, m_rr;
  logic         m_op, m_lat, m_fault;
  logic [N-1:0] m_conf, m_conf_n, e_done;
  bit           rst_sampled, auto_on, drop_on_done;
  int           n_chk = 0;
  int           n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d after reset)", tag, got, exp, m_k);
    end
  endtask

  task automatic check_cycle();
    logic es, er, eok, eq;
    logic [N-1:0] ed;
    bit chk_q;
    es = 1'b0; er = 1'b0; eok = 1'b0; eq = 1'b0; ed = '0;
    chk_q = (m_k == 0);
    if (m_k >= 1 && m_k <= P) er = 1'b1;
    if (m_k == P + G + 1) begin chk_q = 1; eq = m_lat; end
    if (m_g >= 0) begin
      if (m_k >= m_g + 1 && m_k <= m_g + P) begin es = m_op; er = !m_op; end
      if (m_k == m_g + P + G + 1) begin
        ed[m_idx] = 1'b1; eok = (m_lat == m_op); chk_q = 1; eq = m_lat;
      end
    end
    e_done = ed;
    chk("s_drv",    32'(s_drv),         32'(es));
    chk("r_drv",    32'(r_drv),         32'(er));
    chk("both_drv", 32'(s_drv & r_drv), 32'(0));
    chk("done",     32'(done),          32'(ed));
    chk("ok",       32'(ok),            32'(eok));
    chk("busy",     32'(busy),          32'(m_k < m_free));
    chk("fault",    32'(fault),         32'(m_fault));
    chk("conflict", 32'(conflict),      32'(m_conf));
    if (chk_q) chk("q_state", 32'(q_state), 32'(eq));
  endtask

  task automatic update_stim();
    for (int i = 0; i < N; i++) begin
      if (e_done[i] && drop_on_done) begin
        if (!auto_on || $urandom_range(3) != 0) begin
          req_set[i] = 1'b0; req_clr[i] = 1'b0;
        end
      end else if (auto_on) begin
        if (req_set[i] && req_clr[i]) begin
          if ($urandom_range(3) == 0) begin req_set[i] = 1'b0; req_clr[i] = 1'b0; end
        end else if (req_set[i] || req_clr[i]) begin
          if ($urandom_range(31) == 0) begin req_set[i] = 1'b0; req_clr[i] = 1'b0; end
        end else if ($urandom_range(9) == 0) begin
          case ($urandom_range(7))
            0:       begin req_set[i] = 1'b1; req_clr[i] = 1'b1; end
            1, 2, 3: req_set[i] = 1'b1;
            default: req_clr[i] = 1'b1;
          endcase
        end
      end
    end
    if (auto_on) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
    end
  endtask

  task automatic decide();
    bit found;
    found = 0;
    rst_sampled = rst;
    m_conf_n = req_set & req_clr;
    if (!rst && m_k >= m_free) begin
      for (int j = 0; j < N; j++) begin
        int c = (m_rr + j) % N;
        if (!found && (req_set[c] ^ req_clr[c])) begin
          found  = 1;
          m_g    = m_k;
          m_idx  = c;
          m_op   = req_set[c];
          m_rr   = (c + 1) % N;
          m_free = m_k + P + G + 2;
          m_lat  = stuck ? 1'b0 : m_op;
        end
      end
    end
  endtask

  task automatic advance();
    if (rst_sampled) begin
      m_k = 0; m_g = -1; m_free = P + G + 2; m_rr = 0;
      m_fault = 1'b0; m_conf = '0; m_lat = 1'b0;
    end else begin
      if (m_k == P + G + 1 && m_lat != 1'b0) m_fault = 1'b1;
      if (m_g >= 0 && m_k == m_g + P + G + 1 && m_lat != m_op) m_fault = 1'b1;
      m_conf = m_conf_n;
      m_k++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    update_stim();
    decide();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    auto_on = 0; drop_on_done = 1; e_done = '0; m_conf_n = '0;
    m_op = 1'b0; m_idx = 0; m_k = 0;
    @(posedge clk); #1;
    rst_sampled = 1; advance();
    step(); step();
    rst = 1'b0;
    repeat (8) step();

    // single set on requester 2
    req_set[2] = 1'b1;
    repeat (10) step();

    // three simultaneous requests from a fresh pointer, then a wrap race
    pulse_reset();
    repeat (7) step();
    req_set[0] = 1'b1; req_clr[1] = 1'b1; req_set[3] = 1'b1;
    repeat (22) step();
    req_set[0] = 1'b1; req_set[3] = 1'b1;
    repeat (16) step();

    // both bits high on requester 1: conflict only, no service
    req_set[1] = 1'b1; req_clr[1] = 1'b1;
    repeat (10) step();
    req_set[1] = 1'b0; req_clr[1] = 1'b0;
    repeat (2) step();

    // latch stuck at 0: failed set raises a sticky fault
    stuck = 1'b1;
    pulse_reset();
    repeat (8) step();
    req_set[0] = 1'b1;
    repeat (8) step();
    req_clr[0] = 1'b1;
    repeat (8) step();
    stuck = 1'b0;
    pulse_reset();
    repeat (8) step();

    // reset during the second DRIVE cycle of a set
    req_set[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (m_g >= 0 && m_k == m_g + 2) break;
    end
    chk("mid_drive_reached", 32'(m_g >= 0 && m_k == m_g + 2), 32'(1));
    pulse_reset();
    repeat (14) step();

    // random traffic with occasional resets
    auto_on = 1;
    repeat (2000) step();
    auto_on = 0;
    rst = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
